// File: rtl/uart_tx_sched_pkg.sv
// Shared types and default sizing for the UART transmit scheduler.
// The FSM state encoding lives here so that the RTL and any debug tooling use the same values.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } sched_state_e;

    localparam int NREQ_DEF    = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int LOW_TMO_DEF = 4;

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Rotate-priority selector: the search starts one past the last grant and wraps,
// so the requester that was just served has the lowest priority.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]          req,
    input  logic [$clog2(NREQ)-1:0]  last,
    output logic [$clog2(NREQ)-1:0]  idx,
    output logic                     vld
);

    localparam int IDW = $clog2(NREQ);

    always_comb begin : sel
        int c;
        c   = 0;
        idx = '0;
        vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            c = int'(last) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (!vld && req[c]) begin
                vld = 1'b1;
                idx = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmit engine among NREQ byte requesters, round robin,
// with only one byte in flight at a time, paced by the engine's TXRDY handshake.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LOW_TMO = LOW_TMO_DEF
) (
    input  logic                     clk,
    input  logic                     resetNew,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   data,
    input  logic                     txrdy,
    output logic                     write0,
    output logic [DATA_W-1:0]        tx_data,
    output logic [NREQ-1:0]          ack,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     err
);

    localparam int IDW = $clog2(NREQ);
    localparam int TW  = $clog2(LOW_TMO + 1);
    localparam logic [IDW-1:0] GRANT_RST = IDW'(NREQ - 1);
    localparam logic [TW-1:0]  TMO_LIMIT = TW'(LOW_TMO);

    sched_state_e      state_q, state_d;
    logic              write0_q, write0_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [TW-1:0]     tmo_inc;

    logic [IDW-1:0]    pick_idx;
    logic              pick_vld;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (req),
        .last (grant_q),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    assign tmo_inc = tmo_q + 1'b1;

    // write0/ack are decided on the IDLE->LOAD transition so they are registered pulses in LOAD.
    always_comb begin
        state_d   = state_q;
        write0_d  = 1'b0;
        ack_d     = '0;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        case (state_q)
            IDLE: begin
                if (txrdy && pick_vld) begin
                    tx_data_d       = data[pick_idx*DATA_W +: DATA_W];
                    grant_d         = pick_idx;
                    write0_d        = 1'b1;
                    ack_d[pick_idx] = 1'b1;
                    busy_d          = 1'b1;
                    state_d         = LOAD;
                end
            end
            LOAD: begin
                tmo_d   = '0;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!txrdy) begin
                    state_d = WAIT_HIGH;
                end else begin
                    tmo_d = tmo_inc;
                    // Engine never acknowledged the load: the byte is dropped.
                    if (tmo_inc == TMO_LIMIT) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (txrdy) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetNew) begin
        if (resetNew) begin
            state_q   <= IDLE;
            write0_q  <= 1'b0;
            tx_data_q <= '0;
            ack_q     <= '0;
            grant_q   <= GRANT_RST;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            write0_q  <= write0_d;
            tx_data_q <= tx_data_d;
            ack_q     <= ack_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign write0   = write0_q;
    assign tx_data  = tx_data_q;
    assign ack      = ack_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmit engine among up to NREQ byte requesters, e.g. the TramelBlaze port-0 write path, a hardware status-message generator and a loopback echo path. Sits between the requesters and the transmit engine. Drives the engine's write0/out_port load interface and paces loads on the engine's TXRDY handshake, so only one byte is ever in flight. Replaces the direct PORT_ID==0 load decode in the transmit top level.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- DATA_W, 8: byte width; engine out_port is zero-extended to 16 bits by the integrator.
- LOW_TMO, 4: max cycles allowed for TXRDY to fall after a load.

Ports:
- clk  in  1  system clock, 100 MHz.
- resetNew  in  1  reset, asynchronous, active-high; clock clk.
- req  in  NREQ  per-requester byte valid; held with data until matching ack.
- data  in  NREQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- txrdy  in  1  engine ready; high = idle, low = shifting.
- write0  out  1  one-cycle engine load strobe.
- tx_data  out  DATA_W  byte presented to the engine; valid while write0 is high, held afterwards.
- ack  out  NREQ  one-hot, one-cycle pulse; asserted in the same cycle as write0.
- grant_id  out  $clog2(NREQ)  index of the last granted requester.
- busy  out  1  high from load until the engine returns to ready.
- err  out  1  sticky; set on TXRDY-fall timeout; cleared only by reset.

## Operation
- State machine with states IDLE, LOAD, WAIT_LOW and WAIT_HIGH.
- IDLE:
  - Condition: txrdy=1 and req≠0.
  - Action: select the winner, latch its byte into tx_data, record it in grant_id, go to LOAD.
- LOAD:
  - Assert write0 and ack[grant_id] for exactly one cycle.
  - Set busy, clear the timeout counter, go to WAIT_LOW.
- WAIT_LOW:
  - txrdy=0: go to WAIT_HIGH.
  - Timeout counter increments each cycle. On reaching LOW_TMO, set err and return to IDLE; the byte is considered lost.
- WAIT_HIGH:
  - txrdy=1 (rising edge of ready): clear busy, go to IDLE.
- Round robin:
  - Search starts at grant_id+1 and wraps modulo NREQ; the first set req wins.
  - grant_id resets to NREQ-1, so requester 0 has first priority.
  - A lone persistent requester is served back-to-back.
- Requester rule:
  - After ack, a requester drops req or presents its next byte from the following cycle.
  - The scheduler never re-samples a requester in the cycle its ack is high.
- Requests arriving while not in IDLE wait; no request is dropped.
- A req that deasserts before ack is simply not served; this is legal.
- txrdy=0 in IDLE (engine busy from an external source): no grant until it returns high.
- Reset mid-transfer: return to IDLE immediately; the engine is reset by the same resetNew.

## Timing
- Reset values: write0=0, tx_data=0, ack=0, busy=0, err=0, grant_id=NREQ-1, state IDLE, timeout counter 0.
- All outputs are registered.
- Latency: req seen in IDLE at edge N gives write0/ack high during cycle N+1.
- Minimum spacing between write0 pulses is 4 cycles when the engine is instantaneous. In practice the spacing is set by the frame time.
- Simultaneous txrdy rise and new req: busy clears at edge N, the grant decision is made in IDLE at N+1, and write0 follows at N+2.

## Structure
- Package uart_tx_sched_pkg: state enum (IDLE, LOAD, WAIT_LOW, WAIT_HIGH) and default NREQ, DATA_W and LOW_TMO constants.
- Sub-module rr_pick: combinational rotate-priority selector.
  - Inputs: req and the last-grant pointer.
  - Outputs: winner index and valid.
- The FSM, data mux, timeout counter and registered outputs live in uart_tx_scheduler.

## Test plan
- Single request: req=4'b0001, data0=8'h41, txrdy high → write0 and ack=4'b0001 one cycle later, tx_data=8'h41, grant_id=0, busy=1.
- Round robin: all four req held, engine model drops txrdy 1 cycle after write0 and raises it 20 cycles later → grant order 0,1,2,3,0, one write0 per frame.
- Back-to-back single requester: req0 held with bytes 8'h43, 8'h53, 8'h55, 8'h4C → four loads in order, each only after txrdy returns high.
- Timeout: txrdy held at 1 after write0 → after LOW_TMO=4 cycles err=1, busy=0, FSM in IDLE, next req is still served.
- Engine busy externally: txrdy=0 while req0=1 → no write0 until txrdy goes high, then write0 one cycle after the first IDLE sample.
- Reset mid-frame: assert resetNew in WAIT_HIGH → all outputs return to reset values asynchronously, grant_id=3, err cleared.
